// File: rtl/ltc2389_emulator.sv
// Behavioural LTC2389-24 serial-port stand-in: oversamples CNV/SCK and answers with BUSY/SDO.
// Optional feature: define LTC2389_EMU_RAMP_EN to replace i_sample with an internal 24-bit ramp.
`timescale 1ns/1ps

module ltc2389_emulator #(
   parameter int CONV_CYCLES = 40,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        i_reset,
   input  logic        i_cnv,
   input  logic        i_sck,
   input  logic        i_rdl_sdi,
   input  logic        i_chain,
   input  logic [23:0] i_sample,
   output logic        o_busy,
   output logic        o_sdo,
   output logic        o_sdo_oe,
   output logic        o_overrun,
   output logic        o_mode_err
);

   localparam logic [9:0] CNT_LOAD = 10'(CONV_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CONVERT, READOUT, DONE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] cnv_sync, sck_sync;
   logic                   cnv_hist, sck_hist;
   logic [23:0]            shreg;
   logic [4:0]             bitcnt;
   logic [9:0]             busy_cnt;
   logic                   sdo_oe_q, overrun_q, mode_err_q;
   logic                   cnv_edge, sck_edge, shift_en;
   logic                   latch, shift;
   logic [23:0]            sample_src;

   assign cnv_edge = cnv_sync[SYNC_STAGES-1] & ~cnv_hist;
   assign sck_edge = sck_sync[SYNC_STAGES-1] & ~sck_hist;
   // CNV wins over a coincident SCK edge; read-disable blocks shifting.
   assign shift_en = sck_edge & ~cnv_edge & sdo_oe_q;

   always_ff @(posedge clk) begin
      if (!i_reset) begin
         cnv_sync <= '0;
         sck_sync <= '0;
         cnv_hist <= 1'b0;
         sck_hist <= 1'b0;
      end else begin
         cnv_sync <= {cnv_sync[SYNC_STAGES-2:0], i_cnv};
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], i_sck};
         cnv_hist <= cnv_sync[SYNC_STAGES-1];
         sck_hist <= sck_sync[SYNC_STAGES-1];
      end
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      shift   = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (cnv_edge) begin
               state_d = CONVERT;
               latch   = 1'b1;
            end
         end
         CONVERT: begin
            if (busy_cnt == '0) state_d = READOUT;
         end
         READOUT: begin
            if (cnv_edge) begin
               state_d = CONVERT;
               latch   = 1'b1;
            end else if (shift_en) begin
               shift = 1'b1;
               if (bitcnt == 5'd23) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
   always_ff @(posedge clk) begin
      if (!i_reset) begin
         state_q    <= IDLE;
         shreg      <= '0;
         bitcnt     <= '0;
         busy_cnt   <= '0;
         sdo_oe_q   <= 1'b0;
         overrun_q  <= 1'b0;
         mode_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sdo_oe_q   <= ~i_rdl_sdi;
         mode_err_q <= i_chain;
         if (state_q == CONVERT && cnv_edge) overrun_q <= 1'b1;
         if (latch) begin
            shreg    <= sample_src;
            busy_cnt <= CNT_LOAD;
         end else if (state_q == CONVERT) begin
            if (busy_cnt != '0) busy_cnt <= busy_cnt - 10'd1;
            else                bitcnt   <= '0;
         end else if (shift) begin
            shreg  <= {shreg[22:0], 1'b0};
            bitcnt <= bitcnt + 5'd1;
         end
      end
   end

`ifdef LTC2389_EMU_RAMP_EN
   logic [23:0] ramp_q;
   logic        unused_sample;

   assign unused_sample = ^i_sample;
   assign sample_src    = ramp_q;

   always_ff @(posedge clk) begin
      if (!i_reset)   ramp_q <= '0;
      else if (latch) ramp_q <= ramp_q + 24'd1;
   end
`else
   assign sample_src = i_sample;
`endif

   assign o_busy     = (state_q == CONVERT);
   assign o_sdo      = (state_q == READOUT) & shreg[23] & sdo_oe_q;
   assign o_sdo_oe   = sdo_oe_q;
   assign o_overrun  = overrun_q;
   assign o_mode_err = mode_err_q;

endmodule

// File: tb/tb_ltc2389_emulator.sv
// Scoreboard bench for ltc2389_emulator: expected words queued at CNV, compared after each SCK readout.
`timescale 1ns/1ps

module tb_ltc2389_emulator;

   logic        clk = 1'b0;
   logic        i_reset, i_cnv, i_sck, i_rdl_sdi, i_chain;
   logic [23:0] i_sample;
   logic        o_busy, o_sdo, o_sdo_oe, o_overrun, o_mode_err;

   int          n_checks = 0;
   int          n_errors = 0;
   int          busy_run = 0;
   int          last_width = 0;
   logic [23:0] exp_q[$];
   logic [23:0] w;

   always #5 clk = ~clk;

   ltc2389_emulator dut (
      .clk       (clk),
      .i_reset   (i_reset),
      .i_cnv     (i_cnv),
      .i_sck     (i_sck),
      .i_rdl_sdi (i_rdl_sdi),
      .i_chain   (i_chain),
      .i_sample  (i_sample),
      .o_busy    (o_busy),
      .o_sdo     (o_sdo),
      .o_sdo_oe  (o_sdo_oe),
      .o_overrun (o_overrun),
      .o_mode_err(o_mode_err)
   );

   // Width of the most recent BUSY pulse, measured in clk cycles.
   always @(negedge clk) begin
      if (o_busy) busy_run = busy_run + 1;
      else if (busy_run != 0) begin
         last_width = busy_run;
         busy_run   = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic convert(input logic [23:0] s);
      i_sample = s;
      i_cnv    = 1'b1;
      repeat (4) @(negedge clk);
      i_cnv    = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_busy_low();
      int n = 0;
      while (o_busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (o_busy) check("busy_timeout", 32'(o_busy), 32'd0);
      @(negedge clk);
   endtask

   task automatic read_bits(input int n, output logic [23:0] word);
      word = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         word  = {word[22:0], o_sdo};
         i_sck = 1'b1;
         repeat (4) @(negedge clk);
         i_sck = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic check_word(input string tag, input logic [23:0] word);
      if (exp_q.size() == 0) check({tag, "_queue_empty"}, 32'd1, 32'd0);
      else                   check(tag, 32'(word), 32'(exp_q.pop_front()));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      i_reset   = 1'b0;
      i_cnv     = 1'b0;
      i_sck     = 1'b0;
      i_rdl_sdi = 1'b0;
      i_chain   = 1'b0;
      i_sample  = '0;
      repeat (4) @(negedge clk);
      check("rst_busy",     32'(o_busy),     32'd0);
      check("rst_sdo",      32'(o_sdo),      32'd0);
      check("rst_sdo_oe",   32'(o_sdo_oe),   32'd0);
      check("rst_overrun",  32'(o_overrun),  32'd0);
      check("rst_mode_err", 32'(o_mode_err), 32'd0);
      i_reset = 1'b1;
      repeat (2) @(negedge clk);
      check("sdo_oe_after_reset", 32'(o_sdo_oe), 32'd1);

`ifdef LTC2389_EMU_RAMP_EN
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(24'(k));
         convert(24'hFFFFFF);
         wait_busy_low();
         check("ramp_busy_width", 32'(last_width), 32'd40);
         read_bits(24, w);
         check_word("ramp_word", w);
      end
      @(negedge clk);
      dut.ramp_q = 24'hFFFFFF;
      exp_q.push_back(24'hFFFFFF);
      convert(24'h0);
      wait_busy_low();
      read_bits(24, w);
      check_word("ramp_max_word", w);
      exp_q.push_back(24'h000000);
      convert(24'h0);
      wait_busy_low();
      read_bits(24, w);
      check_word("ramp_wrap_word", w);
`else
      // Basic conversion and readout.
      exp_q.push_back(24'hA5F00F);
      convert(24'hA5F00F);
      check("basic_busy_high", 32'(o_busy), 32'd1);
      wait_busy_low();
      check("basic_busy_width", 32'(last_width), 32'd40);
      read_bits(24, w);
      check_word("basic_word", w);
      repeat (2) @(negedge clk);
      check("basic_sdo_after_24", 32'(o_sdo), 32'd0);
      read_bits(1, w);
      check("done_extra_sck_sdo", 32'(o_sdo), 32'd0);

      // Read-disable during the first 12 SCK pulses.
      exp_q.push_back(24'hA5F00F);
      convert(24'hA5F00F);
      wait_busy_low();
      i_rdl_sdi = 1'b1;
      repeat (2) @(negedge clk);
      check("rdl_oe_low", 32'(o_sdo_oe), 32'd0);
      read_bits(12, w);
      check("rdl_sdo_zero", 32'(w), 32'd0);
      check("rdl_oe_still_low", 32'(o_sdo_oe), 32'd0);
      i_rdl_sdi = 1'b0;
      repeat (2) @(negedge clk);
      check("rdl_oe_high", 32'(o_sdo_oe), 32'd1);
      read_bits(24, w);
      check_word("rdl_word", w);

      // Readout abort by a CNV edge after 8 SCK pulses.
      exp_q.push_back(24'hC3C3C3);
      convert(24'hC3C3C3);
      wait_busy_low();
      read_bits(8, w);
      begin
         logic [23:0] e;
         e = exp_q.pop_front();
         check("abort_partial_byte", 32'(w[7:0]), 32'(e[23:16]));
      end
      exp_q.push_back(24'h123456);
      convert(24'h123456);
      check("abort_busy_reasserted", 32'(o_busy), 32'd1);
      check("abort_no_overrun", 32'(o_overrun), 32'd0);
      wait_busy_low();
      check("abort_busy_width", 32'(last_width), 32'd40);
      read_bits(24, w);
      check_word("abort_word", w);

      // Overrun: second CNV 10 clk after the first.
      exp_q.push_back(24'h0F1E2D);
      i_sample = 24'h0F1E2D;
      i_cnv    = 1'b1;
      repeat (4) @(negedge clk);
      i_cnv    = 1'b0;
      repeat (6) @(negedge clk);
      i_sample = 24'h5A0FF0;
      i_cnv    = 1'b1;
      repeat (4) @(negedge clk);
      i_cnv    = 1'b0;
      repeat (4) @(negedge clk);
      check("ovr_set", 32'(o_overrun), 32'd1);
      wait_busy_low();
      check("ovr_busy_width", 32'(last_width), 32'd40);
      read_bits(24, w);
      check_word("ovr_word", w);
      check("ovr_sticky", 32'(o_overrun), 32'd1);

      // Reset while BUSY is high.
      i_chain = 1'b1;
      convert(24'h777777);
      check("mode_err_set", 32'(o_mode_err), 32'd1);
      check("mid_busy_high", 32'(o_busy), 32'd1);
      i_reset = 1'b0;
      @(negedge clk);
      i_reset = 1'b1;
      check("mid_rst_busy",     32'(o_busy),     32'd0);
      check("mid_rst_sdo",      32'(o_sdo),      32'd0);
      check("mid_rst_sdo_oe",   32'(o_sdo_oe),   32'd0);
      check("mid_rst_overrun",  32'(o_overrun),  32'd0);
      check("mid_rst_mode_err", 32'(o_mode_err), 32'd0);
      i_chain = 1'b0;
      repeat (2) @(negedge clk);
      check("post_rst_idle", 32'(o_busy), 32'd0);
      exp_q.push_back(24'h3C5A96);
      convert(24'h3C5A96);
      wait_busy_low();
      check("post_rst_busy_width", 32'(last_width), 32'd40);
      read_bits(24, w);
      check_word("post_rst_word", w);
      check("post_rst_no_overrun", 32'(o_overrun), 32'd0);
`endif

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
